muldiv_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs 32-bit unsigned multiply (MULTU) and unsigned divide (DIVU) by repeatedly driving the shared 32-bit add/sub unit `bit32_add_sub`. The add/sub unit stays purely combinational. This block owns the operand/partial-result registers, the iteration counter and the add/sub control, and produces MIPS HI/LO results for the EX stage. It sits between the EX-stage decode (issues ops) and the HI/LO register file (consumes results).

---
 rtl/muldiv_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl
// Multi-cycle MULTU / DIVU sequencer that time-shares an external
// combinational 32-bit add/sub unit. One iteration is done per clock, 32 in
// total. Results come out in MIPS HI/LO form.
//
// Ports
//   clk_in, rst_in         clock (rising edge), synchronous active-high reset
//   start_in, op_in        op request (00 MULTU, 01 DIVU, 1x reserved), IDLE only
//   A_in, B_in             multiplicand/dividend, multiplier/divisor
//   busy_out               high while iterating
//   done_out, err_out      one-cycle completion pulse, error flag (held)
//   hi_out, lo_out         MULTU: product hi/lo; DIVU: remainder/quotient
//   add_a_out, add_b_out   operands to the add/sub unit
//   add_ctrl_out           0 = add, 1 = subtract
//   add_s_in               sum/difference returned by the add/sub unit
module muldiv_seq_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] add_a_out,
    output logic [31:0] add_b_out,
    output logic        add_ctrl_out,
    input  logic [31:0] add_s_in
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] op_a, op_b;
    logic [31:0] hi, lo;
    logic [4:0]  count;
    logic        is_div;
    logic        err;

    logic        op_rsvd, div_zero, bad_start;
    logic        b_eff, carry, quot;

    assign op_rsvd   = op_in[1];
    assign div_zero  = ~op_in[1] & op_in[0] & (B_in == 32'd0);
    assign bad_start = op_rsvd | div_zero;

    // Carry-out of the adder rebuilt from the MSBs alone. The unit does not
    // export it. For subtract, B is effectively inverted, so carry = 1 means
    // no borrow.
    assign b_eff = add_ctrl_out ? ~add_b_out[31] : add_b_out[31];
    assign carry = (add_a_out[31] & b_eff) | ((add_a_out[31] | b_eff) & ~add_s_in[31]);
    // When hi[31] is set, the shifted partial remainder is >= 2^32 and so
    // exceeds any divisor. The subtraction must happen even though the
    // 32-bit adder reports a borrow.
    assign quot  = hi[31] | carry;

    always_comb begin
        state_nxt    = state;
        add_a_out    = 32'd0;
        add_b_out    = 32'd0;
        add_ctrl_out = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) state_nxt = bad_start ? DONE : RUN;
            end
            RUN: begin
                if (is_div) begin
                    add_a_out    = {hi[30:0], lo[31]};
                    add_b_out    = op_b;
                    add_ctrl_out = 1'b1;
                end else begin
                    add_a_out    = hi;
                    add_b_out    = lo[0] ? op_a : 32'd0;
                end
                if (count == 5'd31) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            count  <= 5'd0;
            is_div <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op_a   <= A_in;
                        op_b   <= B_in;
                        count  <= 5'd0;
                        is_div <= op_in[0];
                        err    <= 1'b0;
                        if (op_rsvd) begin
                            hi  <= 32'd0;
                            lo  <= 32'd0;
                            err <= 1'b1;
                        end else if (div_zero) begin
                            hi  <= A_in;
                            lo  <= 32'hFFFF_FFFF;
                            err <= 1'b1;
                        end else begin
                            hi <= 32'd0;
                            lo <= op_in[0] ? A_in : B_in;
                        end
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (is_div) begin
                        hi <= quot ? add_s_in : {hi[30:0], lo[31]};
                        lo <= {lo[30:0], quot};
                    end else begin
                        hi <= {carry, add_s_in[31:1]};
                        lo <= {add_s_in[0], lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (state == RUN);
    assign done_out = (state == DONE);
    assign err_out  = err;
    assign hi_out   = hi;
    assign lo_out   = lo;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, err;
    logic [31:0] hi, lo, add_a, add_b, add_s;
    logic        add_ctrl;

    int tests = 0;
    int fails = 0;

    muldiv_seq_ctrl dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .op_in(op),
        .A_in(a), .B_in(b), .busy_out(busy), .done_out(done), .err_out(err),
        .hi_out(hi), .lo_out(lo), .add_a_out(add_a), .add_b_out(add_b),
        .add_ctrl_out(add_ctrl), .add_s_in(add_s)
    );

    // Behavioural stand-in for the shared add/sub unit.
    assign add_s = add_ctrl ? (add_a - add_b) : (add_a + add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition.
    task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] mhi, output logic [31:0] mlo,
                         output logic merr, output int mlat);
        logic [63:0] prod;
        if (mop[1]) begin
            mhi = 0; mlo = 0; merr = 1; mlat = 0;
        end else if (mop[0]) begin
            if (mb == 0) begin
                mhi = ma; mlo = 32'hFFFF_FFFF; merr = 1; mlat = 0;
            end else begin
                mhi = ma % mb; mlo = ma / mb; merr = 0; mlat = 32;
            end
        end else begin
            prod = {32'd0, ma} * {32'd0, mb};
            mhi = prod[63:32]; mlo = prod[31:0]; merr = 0; mlat = 32;
        end
    endtask

    // Called at #1 after an edge. The start is sampled at the next edge (E0),
    // and the task returns at #1 after E0.
    task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Counts edges until done is seen. The wait is bounded.
    task automatic wait_done(output int lat, output logic busy_seen);
        lat = 0; busy_seen = 1'b0;
        while (!done && lat < 100) begin
            busy_seen |= busy;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] cop, input logic [31:0] ca,
                            input logic [31:0] cb, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic eerr, input int elat);
        int lat;
        logic bs;
        issue(cop, ca, cb);
        wait_done(lat, bs);
        chk({name, ".lat"}, lat, elat);
        chk({name, ".hi"}, hi, ehi);
        chk({name, ".lo"}, lo, elo);
        chk({name, ".err"}, err, eerr);
        chk({name, ".busy"}, bs, (elat != 0));
        @(posedge clk); #1;
        chk({name, ".pulse"}, done, 1'b0);
        chk({name, ".hold"}, {hi, lo, 31'd0, err}, {ehi, elo, 31'd0, eerr});
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        logic bs;
        int dcnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb, mhi, mlo;
        logic        merr;
        int          mlat;

        vecs[0] = '{2'b00, 32'h0000_0FFF, 32'h0000_3341, 32'h0000_0000, 32'h0333_DCBF, 1'b0, 32};
        vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32};
        vecs[2] = '{2'b01, 32'h0000_3341, 32'h0000_0FFF, 32'h0000_0344, 32'h0000_0003, 1'b0, 32};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 32};
        vecs[4] = '{2'b01, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[5] = '{2'b10, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 0};
        vecs[6] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 0};
        vecs[7] = '{2'b00, 32'h0000_0000, 32'hABCD_1234, 32'h0000_0000, 32'h0000_0000, 1'b0, 32};
        vecs[8] = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 1'b0, 32};
        vecs[9] = '{2'b01, 32'h8765_4321, 32'h0000_0001, 32'h0000_0000, 32'h8765_4321, 1'b0, 32};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = 0; b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.err", err, 1'b0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.adder", {add_a, add_b, 31'd0, add_ctrl}, 96'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].hi, vecs[i].lo, vecs[i].err, vecs[i].lat);

        // A start raised mid-run must be ignored.
        issue(2'b00, 32'h0000_0FFF, 32'h0000_3341);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b01; a = 32'h1111_1111; b = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bs);
        chk("midstart.lat", lat, 26);
        chk("midstart.hilo", {hi, lo}, {32'h0000_0000, 32'h0333_DCBF});
        chk("midstart.err", err, 1'b0);
        @(posedge clk); #1;

        // Reset during RUN aborts the op with no done pulse.
        issue(2'b01, 32'hFFFF_0000, 32'h0000_0123);
        repeat (10) begin @(posedge clk); #1; end
        chk("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.hilo", {hi, lo}, 64'd0);
        chk("abort.adder", {add_a, add_b}, 64'd0);
        dcnt = 0;
        repeat (40) begin
            dcnt += done;
            @(posedge clk); #1;
        end
        chk("abort.no_done", dcnt, 0);
        check_op("after_abort", 2'b00, 32'h0001_0001, 32'h0000_FFFF,
                 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32);

        // Randomised ops against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 5) < 4 ? $urandom_range(0, 1) : $urandom_range(2, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            model(rop, ra, rb, mhi, mlo, merr, mlat);
            check_op($sformatf("rand%0d", i), rop, ra, rb, mhi, mlo, merr, mlat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
